// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, the
// read-modify-write state type and the data-width derivation.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, RMW_WR} state_t;

  function automatic int calc_data_w(input int byte_size);
    return byte_size * 8;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load formatter: sign- or zero-extends a byte or half taken
// from the low lanes of the raw memory word; word (and size 11) passes through.
module load_extender
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{(DATA_W-8){sign_ext & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{(DATA_W-16){sign_ext & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the data memory, performs sub-word stores as a
// two-cycle read-modify-write and owns the MEM/WB register.
// Optional build macro MISALIGN_CHECK_EN adds alignment trapping and misalign_o.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int BYTE_SIZE  = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int REG_W      = 4,
  localparam int DATA_W     = calc_data_w(BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [REG_W-1:0]      rd_i,
  input  logic                  regwrite_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_wd_o,
  input  logic [DATA_W-1:0]     mem_rd_i,
  output logic                  stall_o,
  output logic                  wb_valid_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [REG_W-1:0]      wb_rd_o,
  output logic                  wb_regwrite_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                  misalign_o
`endif
);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [DATA_W-1:0]     rmw_data;
  logic [DATA_W-1:0]     rmw_rd;
  logic [1:0]            rmw_size;

  logic              do_store;
  logic              do_load;
  logic              word_sz;
  logic              misalign;
  logic              start_rmw;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_ext;

  // A load with the store bit also set is handled purely as a store.
  always_comb begin
    do_store = valid_i & is_store_i;
    do_load  = valid_i & is_load_i & ~is_store_i;
    word_sz  = size_i[1];
`ifdef MISALIGN_CHECK_EN
    misalign = valid_i & (is_load_i | is_store_i) &
               (((size_i == SZ_HALF) & addr_i[0]) |
                (word_sz & (addr_i[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    lane_mask = (rmw_size == SZ_BYTE) ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF);
    merged    = (rmw_rd & ~lane_mask) | (rmw_data & lane_mask);
  end

  load_extender #(.DATA_W(DATA_W)) u_load_extender (
    .size     (size_i),
    .sign_ext (sign_ext_i),
    .raw      (mem_rd_i),
    .ext      (load_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Reset overrides everything so a pending RMW write is dropped that cycle.
  always_comb begin
    state_nxt  = state;
    mem_addr_o = addr_i;
    mem_wd_o   = store_data_i;
    mem_we_o   = 1'b0;
    stall_o    = 1'b0;
    start_rmw  = 1'b0;
    case (state)
      IDLE: begin
        if (do_store && !misalign) begin
          if (word_sz) begin
            mem_we_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            start_rmw = 1'b1;
            state_nxt = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_addr_o = rmw_addr;
        mem_wd_o   = merged;
        mem_we_o   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      mem_we_o  = 1'b0;
      stall_o   = 1'b0;
      start_rmw = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rmw_addr <= '0;
      rmw_data <= '0;
      rmw_rd   <= '0;
      rmw_size <= '0;
    end else if (start_rmw) begin
      rmw_addr <= addr_i;
      rmw_data <= store_data_i;
      rmw_rd   <= mem_rd_i;
      rmw_size <= size_i;
    end
  end

  // The stall cycle inserts a bubble; the write cycle retires the store.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_o    <= 1'b0;
      wb_data_o     <= '0;
      wb_rd_o       <= '0;
      wb_regwrite_o <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
    end else if (start_rmw) begin
      wb_valid_o    <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
    end else if (state == RMW_WR) begin
      wb_valid_o    <= 1'b1;
      wb_data_o     <= DATA_W'(rmw_addr);
      wb_rd_o       <= rd_i;
      wb_regwrite_o <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      wb_valid_o    <= valid_i;
      wb_data_o     <= do_load ? load_ext : DATA_W'(addr_i);
      wb_rd_o       <= rd_i;
      wb_regwrite_o <= valid_i & regwrite_i & ~do_store & ~misalign;
`ifdef MISALIGN_CHECK_EN
      misalign_o    <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// misalignment sequences, then random ops checked against a byte-array model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memInit;
  logic        valid_i, is_load_i, is_store_i, sign_ext_i, regwrite_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, store_data_i;
  logic [3:0]  rd_i;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_we_o, stall_o;
  logic        wb_valid_o, wb_regwrite_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_rd_o;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int vecCount  = 0;
  int missCount = 0;

  mem_access_unit #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .REG_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .is_load_i     (is_load_i),
    .is_store_i    (is_store_i),
    .size_i        (size_i),
    .sign_ext_i    (sign_ext_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .rd_i          (rd_i),
    .regwrite_i    (regwrite_i),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wd_o      (mem_wd_o),
    .mem_rd_i      (mem_rd_i),
    .stall_o       (stall_o),
    .wb_valid_o    (wb_valid_o),
    .wb_data_o     (wb_data_o),
    .wb_rd_o       (wb_rd_o),
    .wb_regwrite_o (wb_regwrite_o)
`ifdef MISALIGN_CHECK_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Byte-granular data memory seen by the DUT (256 bytes, address wraps).
  logic [7:0] tbMem [256];
  logic [7:0] memA, memA1, memA2, memA3;
  assign memA  = mem_addr_o[7:0];
  assign memA1 = memA + 8'd1;
  assign memA2 = memA + 8'd2;
  assign memA3 = memA + 8'd3;
  assign mem_rd_i = {tbMem[memA3], tbMem[memA2], tbMem[memA1], tbMem[memA]};

  always @(posedge clk) begin
    if (memInit) begin
      for (int k = 0; k < 256; k++) tbMem[k] <= 8'h00;
      tbMem[0] <= 8'h01;
      tbMem[1] <= 8'h02;
      tbMem[2] <= 8'h03;
      tbMem[3] <= 8'h04;
    end else if (mem_we_o) begin
      for (int k = 0; k < 4; k++) tbMem[8'(memA + k)] <= mem_wd_o[8*k +: 8];
    end
  end

  // Reference model: golden byte memory with arithmetic load/store rules.
  logic [7:0] gold [256];

  function automatic int nBytes(input logic [1:0] s);
    return (s == SZ_BYTE) ? 1 : (s == SZ_HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] goldLoad(input logic [31:0] a, input logic [1:0] s,
                                           input logic sx);
    longint v = 0;
    longint p = 1;
    for (int k = 0; k < nBytes(s); k++) begin
      v = v + longint'(gold[8'(a + k)]) * p;
      p = p * 256;
    end
    if (sx && nBytes(s) < 4 && v >= p / 2) v = v - p;
    return 32'(v);
  endfunction

  function automatic void goldStore(input logic [31:0] a, input logic [1:0] s,
                                    input logic [31:0] d);
    for (int k = 0; k < nBytes(s); k++) gold[8'(a + k)] = d[8*k +: 8];
  endfunction

  function automatic bit isMisaligned(input logic [1:0] s, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
    return (s == SZ_HALF && (a % 2) != 0) || (s[1] && (a % 4) != 0);
`else
    return (s == SZ_HALF && a == 32'hFFFF_FFFF && 1'b0);
`endif
  endfunction

  typedef struct {
    string       name;
    logic        vld, ld, st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr, data;
    logic [3:0]  rd;
    logic        rw;
    logic        expStall, expWe;
    logic [31:0] expWd, expWbData;
    logic        expRw, expMis;
  } vec_t;

  function automatic vec_t mkVec(input string n, input logic vld, ld, st, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] addr, data,
                                 input logic [3:0] rd, input logic rw, input logic expStall,
                                 expWe, input logic [31:0] expWd, expWbData,
                                 input logic expRw, expMis);
    vec_t v;
    v.name = n; v.vld = vld; v.ld = ld; v.st = st; v.sz = sz; v.sx = sx;
    v.addr = addr; v.data = data; v.rd = rd; v.rw = rw;
    v.expStall = expStall; v.expWe = expWe; v.expWd = expWd;
    v.expWbData = expWbData; v.expRw = expRw; v.expMis = expMis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid_i      = v.vld;
    is_load_i    = v.ld;
    is_store_i   = v.st;
    size_i       = v.sz;
    sign_ext_i   = v.sx;
    addr_i       = v.addr;
    store_data_i = v.data;
    rd_i         = v.rd;
    regwrite_i   = v.rw;
  endtask

  // Drives one instruction, holding it through the RMW cycle when stalled.
  task automatic runOp(input vec_t v, input bit chkData);
    applyStimulus(v);
    #1;
    checkOutput({v.name, " stall"}, 32'(stall_o), 32'(v.expStall));
    checkOutput({v.name, " we"}, 32'(mem_we_o), 32'(v.expWe));
    if (v.vld && (v.ld || v.st)) checkOutput({v.name, " addr"}, mem_addr_o, v.addr);
    if (v.expWe) checkOutput({v.name, " wd"}, mem_wd_o, v.expWd);
    @(posedge clk); #1;
    if (v.expStall) begin
      checkOutput({v.name, " rmw we"}, 32'(mem_we_o), 32'd1);
      checkOutput({v.name, " rmw stall"}, 32'(stall_o), 32'd0);
      checkOutput({v.name, " rmw addr"}, mem_addr_o, v.addr);
      checkOutput({v.name, " rmw wd"}, mem_wd_o, v.expWd);
      @(posedge clk); #1;
    end
    checkOutput({v.name, " wb_valid"}, 32'(wb_valid_o), 32'(v.vld));
    if (v.vld) begin
      checkOutput({v.name, " wb_rd"}, 32'(wb_rd_o), 32'(v.rd));
      checkOutput({v.name, " wb_regwrite"}, 32'(wb_regwrite_o), 32'(v.expRw));
      if (chkData) checkOutput({v.name, " wb_data"}, wb_data_o, v.expWbData);
`ifdef MISALIGN_CHECK_EN
      checkOutput({v.name, " misalign"}, 32'(misalign_o), 32'(v.expMis));
`endif
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vt[$];
    vec_t v;

    for (int k = 0; k < 256; k++) gold[k] = 8'h00;
    gold[0] = 8'h01; gold[1] = 8'h02; gold[2] = 8'h03; gold[3] = 8'h04;

    // Reset with a valid word store presented: no write, no stall, wb cleared.
    reset = 1'b1; memInit = 1'b1;
    applyStimulus(mkVec("rst", 1, 0, 1, SZ_WORD, 0, 32'h10, 32'h12345678, 4'd2, 1,
                        0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("reset we", 32'(mem_we_o), 32'd0);
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("reset wb_data", wb_data_o, 32'd0);
    checkOutput("reset wb_rd", 32'(wb_rd_o), 32'd0);
    checkOutput("reset wb_regwrite", 32'(wb_regwrite_o), 32'd0);
    valid_i = 1'b0; reset = 1'b0; memInit = 1'b0;
    @(posedge clk); #1;

    //               name        vld ld st size     sx addr        data          rd  rw  stl we wd            wbdata        rw mis
    vt.push_back(mkVec("lw0",     1, 1, 0, SZ_WORD, 0, 32'h0,      32'h0,         5, 1,  0, 0, 32'h0,        32'h04030201, 1, 0));
    vt.push_back(mkVec("sw0",     1, 0, 1, SZ_WORD, 0, 32'h0,      32'h04800201,  0, 0,  0, 1, 32'h04800201, 32'h0,        0, 0));
    vt.push_back(mkVec("lbs2",    1, 1, 0, SZ_BYTE, 1, 32'h2,      32'h0,         6, 1,  0, 0, 32'h0,        32'hFFFFFF80, 1, 0));
    vt.push_back(mkVec("lbu2",    1, 1, 0, SZ_BYTE, 0, 32'h2,      32'h0,         7, 1,  0, 0, 32'h0,        32'h00000080, 1, 0));
    vt.push_back(mkVec("sw4",     1, 0, 1, SZ_WORD, 0, 32'h4,      32'hDEADBEEF,  0, 0,  0, 1, 32'hDEADBEEF, 32'h4,        0, 0));
    vt.push_back(mkVec("lw4",     1, 1, 0, SZ_WORD, 0, 32'h4,      32'h0,         8, 1,  0, 0, 32'h0,        32'hDEADBEEF, 1, 0));
    vt.push_back(mkVec("sw8",     1, 0, 1, SZ_WORD, 0, 32'h8,      32'h11223344,  0, 0,  0, 1, 32'h11223344, 32'h8,        0, 0));
    vt.push_back(mkVec("sb8",     1, 0, 1, SZ_BYTE, 0, 32'h8,      32'h555555AA,  1, 0,  1, 0, 32'h112233AA, 32'h8,        0, 0));
    vt.push_back(mkVec("lw8",     1, 1, 0, SZ_WORD, 0, 32'h8,      32'h0,         9, 1,  0, 0, 32'h0,        32'h112233AA, 1, 0));
    vt.push_back(mkVec("lhs4",    1, 1, 0, SZ_HALF, 1, 32'h4,      32'h0,        10, 1,  0, 0, 32'h0,        32'hFFFFBEEF, 1, 0));
    vt.push_back(mkVec("lhu4",    1, 1, 0, SZ_HALF, 0, 32'h4,      32'h0,        11, 1,  0, 0, 32'h0,        32'h0000BEEF, 1, 0));
    vt.push_back(mkVec("alu",     1, 0, 0, SZ_WORD, 0, 32'h12345678, 32'h0,       3, 1,  0, 0, 32'h0,        32'h12345678, 1, 0));
    vt.push_back(mkVec("lsz3",    1, 1, 0, 2'b11,   1, 32'h4,      32'h0,        12, 1,  0, 0, 32'h0,        32'hDEADBEEF, 1, 0));
    vt.push_back(mkVec("sh4",     1, 0, 1, SZ_HALF, 0, 32'h4,      32'hAAAA1234,  2, 0,  1, 0, 32'hDEAD1234, 32'h4,        0, 0));
    vt.push_back(mkVec("lw4b",    1, 1, 0, SZ_WORD, 0, 32'h4,      32'h0,        13, 1,  0, 0, 32'h0,        32'hDEAD1234, 1, 0));
    vt.push_back(mkVec("ldst12",  1, 1, 1, SZ_WORD, 0, 32'hC,      32'hCAFEF00D, 14, 0,  0, 1, 32'hCAFEF00D, 32'hC,        0, 0));
    vt.push_back(mkVec("lw12",    1, 1, 0, SZ_WORD, 0, 32'hC,      32'h0,        15, 1,  0, 0, 32'h0,        32'hCAFEF00D, 1, 0));
    vt.push_back(mkVec("invalid", 0, 1, 0, SZ_WORD, 0, 32'h0,      32'h0,         4, 1,  0, 0, 32'h0,        32'h0,        0, 0));

    foreach (vt[i]) begin
      if (vt[i].vld && vt[i].st) goldStore(vt[i].addr, vt[i].sz, vt[i].data);
      runOp(vt[i], 1'b1);
    end

    // Half store whose RMW write cycle is hit by reset: write dropped, wb cleared.
    applyStimulus(mkVec("rstRmw", 1, 0, 1, SZ_HALF, 0, 32'h8, 32'h0000BEEF, 6, 0,
                        0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("rstRmw stall", 32'(stall_o), 32'd1);
    checkOutput("rstRmw first we", 32'(mem_we_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("rstRmw we", 32'(mem_we_o), 32'd0);
    checkOutput("rstRmw stall2", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; reset = 1'b0;
    checkOutput("rstRmw wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("rstRmw wb_data", wb_data_o, 32'd0);
    checkOutput("rstRmw wb_rd", 32'(wb_rd_o), 32'd0);
    checkOutput("rstRmw wb_regwrite", 32'(wb_regwrite_o), 32'd0);
    runOp(mkVec("rstRmwReload", 1, 1, 0, SZ_WORD, 0, 32'h8, 32'h0, 7, 1,
                0, 0, 0, 32'h112233AA, 1, 0), 1'b1);

`ifdef MISALIGN_CHECK_EN
    runOp(mkVec("misSw2", 1, 0, 1, SZ_WORD, 0, 32'h2, 32'h01020304, 0, 0,
                0, 0, 0, 32'h2, 0, 1), 1'b1);
    runOp(mkVec("misReload", 1, 1, 0, SZ_WORD, 0, 32'h0, 32'h0, 3, 1,
                0, 0, 0, 32'h04800201, 1, 0), 1'b1);
`endif

    // Random instruction mix against the golden memory.
    for (int n = 0; n < 400; n++) begin
      int          kind;
      logic        vld, ld, st, sx, rw, mis, stl, we;
      logic [1:0]  sz;
      logic [31:0] a, d, wd, wbd;
      kind = int'($urandom_range(0, 9));
      vld  = (kind != 9);
      ld   = (kind <= 3) || (kind == 7) || (kind == 9);
      st   = (kind >= 4) && (kind <= 7);
      sz   = 2'($urandom_range(0, 3));
      sx   = 1'($urandom);
      a    = $urandom;
      d    = $urandom;
      rw   = st ? 1'b0 : 1'($urandom);
      mis  = vld && (ld || st) && isMisaligned(sz, a);
      stl  = vld && st && !sz[1] && !mis;
      we   = vld && st && sz[1] && !mis;
      wbd  = (vld && ld && !st) ? goldLoad(a, sz, sx) : a;
      if (vld && st && !mis) goldStore(a, sz, d);
      wd   = goldLoad(a, SZ_WORD, 1'b0);
      v = mkVec("rnd", vld, ld, st, sz, sx, a, d, 4'($urandom), rw, stl, we, wd, wbd,
                vld && rw && !st && !mis, mis);
      runOp(v, !mis);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
